// File: rtl/injector_pulse_timer_pkg.sv
// Shared types and default widths for the injector pulse timer and its register bank.
// The timing struct mirrors the SPI-loaded words W, P, N and H.
package inj_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_PER_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEAK = 2'd1,
    HOLD = 2'd2
  } inj_timer_state_t;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] w;
    logic [DEF_CNT_W-1:0] p;
    logic [DEF_PER_W-1:0] n;
    logic [DEF_PER_W-1:0] h;
  } inj_timing_t;

endpackage

// File: rtl/injector_pulse_timer_if.sv
// Trigger, timing-word and strobe bundle between the sequencer side and the pulse timer.
// The master drives requests and timing words; the slave (the timer) drives the strobes.
interface injector_pulse_timer_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 12
);

  logic             i_trigger;
  logic             i_abort;
  logic [CNT_W-1:0] i_pulse_width;
  logic [CNT_W-1:0] i_peak_time;
  logic [PER_W-1:0] i_hold_period;
  logic [PER_W-1:0] i_hold_on;
  logic             o_enable;
  logic             o_peak;
  logic             o_period;
  logic             o_hold;
  logic             o_busy;
  logic             o_done;
  logic             o_overlap;

  modport master (
    output i_trigger, i_abort, i_pulse_width, i_peak_time, i_hold_period, i_hold_on,
    input  o_enable, o_peak, o_period, o_hold, o_busy, o_done, o_overlap
  );

  modport slave (
    input  i_trigger, i_abort, i_pulse_width, i_peak_time, i_hold_period, i_hold_on,
    output o_enable, o_peak, o_period, o_hold, o_busy, o_done, o_overlap
  );

endinterface

// File: rtl/injector_pulse_timer_chop.sv
// Wrapping hold-chop counter: p restarts at 0 on entry to HOLD and wraps from N-1 to 0.
// Strobes are registered and computed from the next count so they line up with p.
module inj_chop_counter #(
  parameter int PER_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic             i_adv,
  input  logic [PER_W-1:0] i_period_len,
  input  logic [PER_W-1:0] i_on_len,
  output logic             o_period,
  output logic             o_hold
);

  logic [PER_W-1:0] p;
  logic [PER_W-1:0] p_n;
  logic             active_n;
  logic             period_n;
  logic             hold_n;

  // N==0 parks the count at 0; H>=N suppresses the hold-off strobe entirely.
  always_comb begin
    p_n      = p;
    active_n = 1'b0;
    if (i_clr) begin
      p_n = '0;
    end else if (i_start) begin
      p_n      = '0;
      active_n = 1'b1;
    end else if (i_adv) begin
      active_n = 1'b1;
      if (i_period_len == '0 || p == i_period_len - PER_W'(1)) begin
        p_n = '0;
      end else begin
        p_n = p + PER_W'(1);
      end
    end
    period_n = active_n && (i_period_len != '0) && (p_n == '0);
    hold_n   = active_n && (i_on_len < i_period_len) && (p_n == i_on_len);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      p        <= '0;
      o_period <= 1'b0;
      o_hold   <= 1'b0;
    end else begin
      p        <= p_n;
      o_period <= period_n;
      o_hold   <= hold_n;
    end
  end

endmodule

// File: rtl/injector_pulse_timer.sv
// Peak-and-hold timing generator feeding the single-injector drive FSM.
// All strobes are registered; next-cycle values are derived from the next state.
module injector_pulse_timer
  import inj_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PER_W = DEF_PER_W
) (
  input logic i_clk,
  input logic i_rst,
  injector_pulse_timer_if.slave bus
);

  inj_timer_state_t state;
  inj_timer_state_t state_n;

  logic [CNT_W-1:0] e;
  logic [CNT_W-1:0] e_n;
  logic [CNT_W-1:0] w_q;
  logic [CNT_W-1:0] w_n;
  logic [CNT_W-1:0] p_q;
  logic [CNT_W-1:0] p_n;
  logic [PER_W-1:0] n_q;
  logic [PER_W-1:0] n_n;
  logic [PER_W-1:0] h_q;
  logic [PER_W-1:0] h_n;

  logic peak_n;
  logic done_n;
  logic overlap_n;
  logic chop_start;
  logic chop_adv;
  logic chop_clr;

  logic enable_q;
  logic busy_q;
  logic peak_q;
  logic done_q;
  logic overlap_q;

  // e counts enable cycles from 0; HOLD is entered in the very cycle e reaches P.
  always_comb begin
    state_n    = state;
    e_n        = e;
    w_n        = w_q;
    p_n        = p_q;
    n_n        = n_q;
    h_n        = h_q;
    peak_n     = 1'b0;
    done_n     = 1'b0;
    overlap_n  = 1'b0;
    chop_start = 1'b0;
    chop_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_trigger && !bus.i_abort && bus.i_pulse_width != '0) begin
          w_n = bus.i_pulse_width;
          p_n = bus.i_peak_time;
          n_n = bus.i_hold_period;
          h_n = bus.i_hold_on;
          e_n = '0;
          if (bus.i_peak_time == '0) begin
            state_n    = HOLD;
            peak_n     = 1'b1;
            chop_start = 1'b1;
          end else begin
            state_n = PEAK;
          end
        end
      end
      default: begin
        overlap_n = bus.i_trigger && !bus.i_abort;
        if (bus.i_abort) begin
          state_n = IDLE;
          e_n     = '0;
        end else if (e == w_q - CNT_W'(1)) begin
          state_n = IDLE;
          e_n     = '0;
          done_n  = 1'b1;
        end else begin
          e_n = (e == '1) ? e : e + CNT_W'(1);
          if (state == PEAK && e_n == p_q) begin
            state_n    = HOLD;
            peak_n     = 1'b1;
            chop_start = 1'b1;
          end else if (state == HOLD) begin
            chop_adv = 1'b1;
          end
        end
      end
    endcase
    chop_clr = (state_n == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      e         <= '0;
      w_q       <= '0;
      p_q       <= '0;
      n_q       <= '0;
      h_q       <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      peak_q    <= 1'b0;
      done_q    <= 1'b0;
      overlap_q <= 1'b0;
    end else begin
      state     <= state_n;
      e         <= e_n;
      w_q       <= w_n;
      p_q       <= p_n;
      n_q       <= n_n;
      h_q       <= h_n;
      enable_q  <= (state_n != IDLE);
      busy_q    <= (state_n != IDLE);
      peak_q    <= peak_n;
      done_q    <= done_n;
      overlap_q <= overlap_n;
    end
  end

  // Fed the next latched words so a P==0 start can chop from the first enable cycle.
  inj_chop_counter #(
    .PER_W(PER_W)
  ) u_chop (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (chop_clr),
    .i_start     (chop_start),
    .i_adv       (chop_adv),
    .i_period_len(n_n),
    .i_on_len    (h_n),
    .o_period    (bus.o_period),
    .o_hold      (bus.o_hold)
  );

  assign bus.o_enable  = enable_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_peak    = peak_q;
  assign bus.o_done    = done_q;
  assign bus.o_overlap = overlap_q;

endmodule

// File: tb/tb_injector_pulse_timer.sv
// Self-checking bench: directed test-plan scenarios plus random triggers/aborts,
// compared each cycle against a per-cycle expectation table built from W, P, N, H.
module tb_injector_pulse_timer;
  import inj_pkg::*;

  localparam int MAXC = 8192;
  localparam int EN  = 6;
  localparam int PK  = 5;
  localparam int PER = 4;
  localparam int HLD = 3;
  localparam int BSY = 2;
  localparam int DN  = 1;
  localparam int OVL = 0;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  logic [6:0] exp_tab [MAXC];

  injector_pulse_timer_if #(.CNT_W(16), .PER_W(12)) bus ();

  injector_pulse_timer #(.CNT_W(16), .PER_W(12)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] observed();
    return {bus.o_enable, bus.o_peak, bus.o_period, bus.o_hold,
            bus.o_busy, bus.o_done, bus.o_overlap};
  endfunction

  task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=%b expected=%b (en,pk,per,hld,bsy,dn,ovl)", tag, obs, expv);
    end
  endtask

  // A fresh pulse triggered in cycle t0: enable for W cycles, peak at P, chop from peak to the end.
  task automatic schedulePulse(input int t0, input int w, input int p, input int n, input int h);
    for (int k = 1; k <= w; k++) begin
      exp_tab[t0+k][EN]  = 1'b1;
      exp_tab[t0+k][BSY] = 1'b1;
    end
    if (p < w) begin
      exp_tab[t0+1+p][PK] = 1'b1;
      for (int c = t0 + 1 + p; c <= t0 + w; c++) begin
        int q;
        q = (n != 0) ? (c - (t0 + 1 + p)) % n : 0;
        if (n != 0 && q == 0) exp_tab[c][PER] = 1'b1;
        if (h < n && q == h) exp_tab[c][HLD] = 1'b1;
      end
    end
    exp_tab[t0+w+1][DN] = 1'b1;
  endtask

  task automatic modelStep(input logic trg, input logic abt, input int w, input int p,
                           input int n, input int h);
    logic busy;
    busy = exp_tab[cyc][BSY];
    if (abt) begin
      if (busy) begin
        for (int c = cyc + 1; c < MAXC && c <= cyc + 200; c++) exp_tab[c] = '0;
      end
    end else if (trg) begin
      if (busy) exp_tab[cyc+1][OVL] = 1'b1;
      else if (w != 0) schedulePulse(cyc, w, p, n, h);
    end
  endtask

  task automatic applyStimulus(input logic trg, input logic abt, input logic [15:0] w,
                               input logic [15:0] p, input logic [11:0] n, input logic [11:0] h);
    @(posedge clk);
    #1;
    cyc++;
    bus.i_trigger     = trg;
    bus.i_abort       = abt;
    bus.i_pulse_width = w;
    bus.i_peak_time   = p;
    bus.i_hold_period = n;
    bus.i_hold_on     = h;
    modelStep(trg, abt, int'(w), int'(p), int'(n), int'(h));
    @(negedge clk);
    checkOutput($sformatf("cyc%0d", cyc), observed(), exp_tab[cyc]);
  endtask

  // Quiet cycles still present changing words, which a running pulse must ignore.
  task automatic idleCycles(input int num);
    for (int i = 0; i < num; i++) begin
      applyStimulus(1'b0, 1'b0, 16'($urandom_range(0, 60)), 16'($urandom_range(0, 60)),
                    12'($urandom_range(0, 9)), 12'($urandom_range(0, 9)));
    end
  endtask

  task automatic doReset(input int num);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b1;
    bus.i_trigger = 1'b0;
    bus.i_abort   = 1'b0;
    #1;
    for (int c = cyc; c < MAXC; c++) exp_tab[c] = '0;
    checkOutput("async_rst", observed(), exp_tab[cyc]);
    for (int i = 0; i < num; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      @(negedge clk);
      checkOutput("in_rst", observed(), exp_tab[cyc]);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    cyc      = 0;
    checks   = 0;
    failures = 0;
    for (int c = 0; c < MAXC; c++) exp_tab[c] = '0;
    bus.i_trigger     = 1'b0;
    bus.i_abort       = 1'b0;
    bus.i_pulse_width = '0;
    bus.i_peak_time   = '0;
    bus.i_hold_period = '0;
    bus.i_hold_on     = '0;
    #2;
    doReset(3);

    $display("[TB] scenario: W=20 P=5 N=4 H=2");
    applyStimulus(1'b1, 1'b0, 16'd20, 16'd5, 12'd4, 12'd2);
    idleCycles(25);

    $display("[TB] scenario: P==W, no peak");
    applyStimulus(1'b1, 1'b0, 16'd10, 16'd10, 12'd4, 12'd1);
    idleCycles(14);

    $display("[TB] scenario: N==0 and H==N");
    applyStimulus(1'b1, 1'b0, 16'd20, 16'd3, 12'd0, 12'd0);
    idleCycles(24);
    applyStimulus(1'b1, 1'b0, 16'd20, 16'd3, 12'd4, 12'd4);
    idleCycles(24);

    $display("[TB] scenario: P==0 and W==1");
    applyStimulus(1'b1, 1'b0, 16'd6, 16'd0, 12'd3, 12'd1);
    idleCycles(9);
    applyStimulus(1'b1, 1'b0, 16'd1, 16'd0, 12'd2, 12'd0);
    idleCycles(4);

    $display("[TB] scenario: abort with simultaneous trigger");
    applyStimulus(1'b1, 1'b0, 16'd30, 16'd5, 12'd4, 12'd2);
    idleCycles(11);
    applyStimulus(1'b1, 1'b1, 16'd9, 16'd2, 12'd3, 12'd1);
    idleCycles(25);

    $display("[TB] scenario: overlap and back-to-back retrigger");
    applyStimulus(1'b1, 1'b0, 16'd20, 16'd5, 12'd4, 12'd2);
    idleCycles(4);
    applyStimulus(1'b1, 1'b0, 16'd7, 16'd1, 12'd2, 12'd0);
    idleCycles(15);
    applyStimulus(1'b1, 1'b0, 16'd8, 16'd2, 12'd3, 12'd1);
    idleCycles(12);

    $display("[TB] scenario: zero width trigger and idle abort");
    applyStimulus(1'b1, 1'b0, 16'd0, 16'd3, 12'd4, 12'd2);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, 16'd5, 16'd1, 12'd2, 12'd1);
    idleCycles(3);

    $display("[TB] scenario: async reset mid-hold");
    applyStimulus(1'b1, 1'b0, 16'd20, 16'd5, 12'd4, 12'd2);
    idleCycles(9);
    doReset(2);
    applyStimulus(1'b1, 1'b0, 16'd20, 16'd5, 12'd4, 12'd2);
    idleCycles(25);

    $display("[TB] random phase");
    for (int i = 0; i < 3000; i++) begin
      logic        trg;
      logic        abt;
      inj_timing_t tw;
      trg  = ($urandom_range(0, 7) == 0);
      abt  = ($urandom_range(0, 39) == 0);
      if (trg && abt && !exp_tab[cyc+1][BSY]) abt = 1'b0;
      tw.w = 16'($urandom_range(0, 40));
      tw.p = 16'($urandom_range(0, 45));
      tw.n = 12'($urandom_range(0, 8));
      tw.h = 12'($urandom_range(0, 9));
      applyStimulus(trg, abt, tw.w, tw.p, tw.n, tw.h);
    end
    idleCycles(45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/injector_pulse_timer.md
Name: injector_pulse_timer

Overview:
Per-channel timing generator that sits directly upstream of the single-injector drive FSM. It turns a start trigger and SPI-loaded timing words into the enable window, peak-elapsed strobe, hold-chop period tick and hold-off strobe that the FSM consumes to sequence the drive and flyback outputs. It implements open-loop peak-and-hold timing; current-sense comparators may be OR-ed in outside this block.

Parameters:
CNT_W, 16, width of pulse-width and peak-time counters (cycles)
PER_W, 12, width of hold-chop period and on-time counters (cycles)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_trigger  in  1  single-cycle start request
i_abort  in  1  terminate active pulse
i_pulse_width  in  CNT_W  total enable length W, cycles
i_peak_time  in  CNT_W  cycles from enable rise to peak strobe, P
i_hold_period  in  PER_W  hold-chop period length N, cycles
i_hold_on  in  PER_W  on-time within each chop period H, cycles
o_enable  out  1  injection window, to FSM i_enable
o_peak  out  1  one-cycle peak-elapsed strobe, to FSM i_peak
o_period  out  1  one-cycle chop period-start strobe, to FSM i_period
o_hold  out  1  one-cycle hold-off strobe, to FSM i_hold
o_busy  out  1  pulse in progress
o_done  out  1  one-cycle strobe on normal completion
o_overlap  out  1  one-cycle strobe: trigger rejected while busy

Behaviour:
- Reset: i_clk and an asynchronous, active-high i_rst. Reset drives every output to 0, the state to IDLE and all counters to 0. Reset mid-pulse drops o_enable immediately.
- All outputs are registered.
- States:
  - IDLE: o_busy=0.
  - PEAK: o_enable=1, o_busy=1.
  - HOLD: o_enable=1, o_busy=1.
- Start:
  - i_trigger in IDLE with i_pulse_width!=0 latches W, P, N and H.
  - Next edge: state PEAK; elapsed counter e=0; o_enable goes high (1-cycle latency).
  - i_trigger with W==0 is ignored; no outputs change.
- Enable window: o_enable is high for exactly W cycles (e=0..W-1). At e==W-1, the next edge goes to IDLE and pulses o_done for 1 cycle (the cycle o_enable is low).
- Peak: in the cycle where e==P and P<W, o_peak=1 and the state becomes HOLD in that same cycle.
  - P==0: o_peak coincides with the first enable cycle.
  - P>=W: no o_peak and no HOLD; the pulse ends in PEAK.
- Hold chop: period counter p=0 at entry to HOLD; p increments each cycle and wraps from N-1 to 0.
  - o_period=1 when p==0 (first tick coincides with o_peak).
  - o_hold=1 when p==H.
  - H>=N: o_hold never fires (100% duty).
  - N==0: no chopping; o_period and o_hold stay 0 throughout HOLD.
- Abort:
  - i_abort while busy: the next edge forces IDLE, o_enable=0, and p/e are cleared. o_done is not pulsed.
  - Abort and trigger in the same cycle: abort wins; the trigger is ignored.
  - i_abort in IDLE has no effect.
- Retrigger:
  - i_trigger while busy is ignored and pulses o_overlap.
  - i_trigger in the o_done cycle (state IDLE) is accepted normally, giving back-to-back pulses with a single low cycle.
- Latched words: input timing words may change during a pulse; only the values latched at start are used.
- Counters: e saturates at its maximum and never wraps; W fits CNT_W, so no overflow is possible.

Decomposition:
- Shared package inj_pkg:
  - state enum inj_timer_state_t {IDLE, PEAK, HOLD}.
  - Default widths CNT_W and PER_W.
  - Timing-word struct inj_timing_t (W, P, N, H) for the SPI register bank.
- One sub-module is natural: inj_chop_counter, the wrapping PER_W counter with enable, clear, period-start strobe and on-time compare strobe.

Test Plan:
- W=20, P=5, N=4, H=2, trigger at cycle 0:
  - o_enable high for cycles 1-20.
  - o_peak and o_period at cycle 6.
  - o_period at 10, 14, 18.
  - o_hold at 8, 12, 16, 20.
  - o_done at 21.
- W=10, P=10: no o_peak, o_period or o_hold. o_enable is high for 10 cycles, then o_done.
- W=20, P=3, N=0: o_peak at cycle 4; no o_period or o_hold. Repeat with N=4, H=4: o_period only, no o_hold.
- W=30, P=5, N=4, H=2, i_abort at cycle 12: o_enable low from cycle 13, no further strobes, no o_done. A trigger at cycle 12 alongside the abort is ignored.
- Trigger at cycle 5 during a W=20 pulse: o_overlap pulses once and the timing is unchanged. A trigger in the o_done cycle starts a second pulse one cycle later.
- Assert i_rst asynchronously mid-HOLD: all outputs go 0 before the next edge. After release, a trigger behaves as in the first scenario.
